// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous imem read port and
// registers {instruction, address, valid} into IF/ID with a one-entry skid buffer.
module instr_fetch #(
    parameter int                ADDR_W   = 14,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 14'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              imem_en_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic [DATA_W-1:0] Instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              valid_o
);

    typedef enum logic [1:0] {IDLE, RUN, SKID} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                req_vld_q, req_vld_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                hold_vld_q, hold_vld_d;
    logic [DATA_W-1:0]   hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                issue;

    // rst_n is an active-high reset despite its name.
    assign issue       = (state_q != IDLE) && !stall_i && !jump_i && !rst_n;
    assign imem_en_o   = issue;
    assign imem_addr_o = pc_q;
    assign Instr_o     = instr_q;
    assign addr_o      = addr_q;
    assign valid_o     = valid_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        pc_d         = issue ? pc_q + ADDR_W'(4) : pc_q;
        req_vld_d    = issue;
        req_addr_d   = issue ? pc_q : req_addr_q;
        hold_vld_d   = hold_vld_q;
        hold_instr_d = hold_instr_q;
        hold_addr_d  = hold_addr_q;
        instr_d      = instr_q;
        addr_d       = addr_q;
        valid_d      = valid_q;

        if (jump_i) begin
            pc_d       = {jump_addr_i[ADDR_W-1:2], 2'b00};
            req_vld_d  = 1'b0;
            hold_vld_d = 1'b0;
            instr_d    = '0;
            addr_d     = '0;
            valid_d    = 1'b0;
            state_d    = RUN;
        end else begin
            unique case (state_q)
                IDLE: begin
                    instr_d = '0;
                    addr_d  = '0;
                    valid_d = 1'b0;
                    state_d = RUN;
                end
                RUN: begin
                    if (!stall_i) begin
                        instr_d = req_vld_q ? imem_data_i : '0;
                        addr_d  = req_vld_q ? req_addr_q  : '0;
                        valid_d = req_vld_q;
                    end else if (req_vld_q) begin
                        // Read data lasts one cycle only, so park it while IF/ID is blocked.
                        hold_vld_d   = 1'b1;
                        hold_instr_d = imem_data_i;
                        hold_addr_d  = req_addr_q;
                        state_d      = SKID;
                    end
                end
                SKID: begin
                    if (!stall_i) begin
                        instr_d    = hold_instr_q;
                        addr_d     = hold_addr_q;
                        valid_d    = 1'b1;
                        hold_vld_d = 1'b0;
                        state_d    = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_vld_q    <= 1'b0;
            req_addr_q   <= '0;
            hold_vld_q   <= 1'b0;
            hold_instr_q <= '0;
            hold_addr_q  <= '0;
            instr_q      <= '0;
            addr_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_vld_q    <= req_vld_d;
            req_addr_q   <= req_addr_d;
            hold_vld_q   <= hold_vld_d;
            hold_instr_q <= hold_instr_d;
            hold_addr_q  <= hold_addr_d;
            instr_q      <= instr_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random reset/jump/stall traffic,
// checked against a queue-based transaction model of the fetch stream.
module tb_instr_fetch;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 14'h0000;

    logic              clk = 1'b0;
    logic              rst_n, stall_i, jump_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              imem_en_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_data_i;
    logic [DATA_W-1:0] Instr_o;
    logic [ADDR_W-1:0] addr_o;
    logic              valid_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction model: fetched-but-undelivered addresses in issue order.
    logic [ADDR_W-1:0] m_q[$];
    logic [ADDR_W-1:0] m_pc;
    logic              m_idle;
    logic [DATA_W-1:0] m_instr;
    logic [ADDR_W-1:0] m_addr;
    logic              m_valid;
    logic              m_known = 1'b0;

    instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall_i),
        .jump_i      (jump_i),
        .jump_addr_i (jump_addr_i),
        .imem_en_o   (imem_en_o),
        .imem_addr_o (imem_addr_o),
        .imem_data_i (imem_data_i),
        .Instr_o     (Instr_o),
        .addr_o      (addr_o),
        .valid_o     (valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a ^ 14'h2A5, 4'hA, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_edge(input logic r, input logic j, input logic s,
                              input logic [ADDR_W-1:0] ja);
        logic [ADDR_W-1:0] a;
        if (r) begin
            m_pc = RESET_PC; m_idle = 1'b1; m_q.delete();
            m_instr = '0; m_addr = '0; m_valid = 1'b0;
        end else if (j) begin
            m_pc = ja & ~ADDR_W'(3); m_idle = 1'b0; m_q.delete();
            m_instr = '0; m_addr = '0; m_valid = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
            m_instr = '0; m_addr = '0; m_valid = 1'b0;
        end else if (!s) begin
            if (m_q.size() > 0) begin
                a = m_q.pop_front();
                m_instr = mem_word(a); m_addr = a; m_valid = 1'b1;
            end else begin
                m_instr = '0; m_addr = '0; m_valid = 1'b0;
            end
            m_q.push_back(m_pc);
            m_pc = m_pc + ADDR_W'(4);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic r, input logic j, input logic s,
                        input logic [ADDR_W-1:0] ja);
        logic              en_s;
        logic [ADDR_W-1:0] addr_s;
        rst_n = r; jump_i = j; stall_i = s; jump_addr_i = ja;
        #1;
        en_s   = imem_en_o;
        addr_s = imem_addr_o;
        if (m_known) begin
            check("imem_en", 64'(imem_en_o), 64'(!r && !j && !s && !m_idle));
            check("imem_addr", 64'(imem_addr_o), 64'(m_pc));
        end
        @(posedge clk);
        #1;
        imem_data_i = en_s ? mem_word(addr_s) : $urandom;
        model_edge(r, j, s, ja);
        m_known = 1'b1;
        check("instr", 64'(Instr_o), 64'(m_instr));
        check("addr", 64'(addr_o), 64'(m_addr));
        check("valid", 64'(valid_o), 64'(m_valid));
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic expect_out(input string tag, input logic [ADDR_W-1:0] a, input logic v);
        check({tag, "_addr"}, 64'(addr_o), 64'(a));
        check({tag, "_valid"}, 64'(valid_o), 64'(v));
    endtask

    task automatic do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        rst_n = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0;
        imem_data_i = '0;
        m_pc = RESET_PC; m_idle = 1'b1;
        m_instr = '0; m_addr = '0; m_valid = 1'b0;
        @(negedge clk);

        // Reset release timing
        do_reset();
        run(1); expect_out("rst_e1", 14'h0000, 1'b0);
        run(1); expect_out("rst_e2", 14'h0000, 1'b0);
        run(1); expect_out("rst_e3", 14'h0000, 1'b1);
        check("rst_e3_instr", 64'(Instr_o), 64'(mem_word(14'h0000)));
        run(1); expect_out("rst_e4", 14'h0004, 1'b1);

        // PC wrap
        step(1'b0, 1'b1, 1'b0, 14'h3FF8);
        run(2); expect_out("wrap0", 14'h3FF8, 1'b1);
        run(1); expect_out("wrap1", 14'h3FFC, 1'b1);
        run(1); expect_out("wrap2", 14'h0000, 1'b1);
        run(1); expect_out("wrap3", 14'h0004, 1'b1);

        // Stall of three cycles while streaming at 0x0010
        do_reset();
        run(7); expect_out("pre_stall", 14'h0010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            expect_out("stall_hold", 14'h0010, 1'b1);
        end
        run(1); expect_out("stall_rel0", 14'h0014, 1'b1);
        run(1); expect_out("stall_rel1", 14'h0018, 1'b1);

        // Jump with unaligned target
        step(1'b0, 1'b1, 1'b0, 14'h0103); expect_out("jmp_b0", 14'h0000, 1'b0);
        run(1); expect_out("jmp_b1", 14'h0000, 1'b0);
        run(1); expect_out("jmp_t0", 14'h0100, 1'b1);
        run(1); expect_out("jmp_t1", 14'h0104, 1'b1);

        // Jump while the skid entry is full
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b1, 1'b1, 14'h0200); expect_out("skjmp_b0", 14'h0000, 1'b0);
        run(1); expect_out("skjmp_b1", 14'h0000, 1'b0);
        run(1); expect_out("skjmp_t", 14'h0200, 1'b1);

        // Reset while the skid entry is full
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, '0); expect_out("skrst", 14'h0000, 1'b0);
        check("skrst_instr", 64'(Instr_o), 64'd0);
        run(2); expect_out("skrst_e2", 14'h0000, 1'b0);
        run(1); expect_out("skrst_e3", 14'h0000, 1'b1);
        run(1); expect_out("skrst_e4", 14'h0004, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(11) == 0),
                 ($urandom_range(3) == 0), ADDR_W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the pipelined core: owns the program counter, drives the synchronous instruction-memory read port, and writes the fetched instruction and its address into the IF/ID pipeline register. It absorbs downstream stalls with a one-entry skid buffer so no fetched word is lost or duplicated. On a jump it flushes in-flight work and emits NOP bubbles (all-zero instruction, zero address).

## Interface
- ADDR_W, 14, byte address width of PC and instruction memory
- DATA_W, 32, instruction width
- RESET_PC, 14'h0000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-high (1 = reset) despite the name
- stall_i  in  1  IF/ID cannot accept this cycle; outputs must hold
- jump_i  in  1  redirect PC; flush in-flight and buffered fetches
- jump_addr_i  in  ADDR_W  redirect target (bits [1:0] ignored, forced 0)
- imem_en_o  out  1  read request this cycle
- imem_addr_o  out  ADDR_W  read address (= PC)
- imem_data_i  in  DATA_W  read data, valid the cycle after the request
- Instr_o  out  DATA_W  fetched instruction to IF/ID
- addr_o  out  ADDR_W  address of Instr_o
- valid_o  out  1  Instr_o/addr_o carry a real fetch

## Operation
- Registers: pc, req_vld/req_addr (request issued last cycle), hold_vld/hold_instr/hold_addr (skid entry), output regs, state.
- States: IDLE (after reset), RUN (hold empty), SKID (hold full).
- imem_addr_o = pc always; imem_en_o = (state != IDLE) && !stall_i && !jump_i && !rst_n.
- On issue: pc <= pc + 4 (mod 2^ADDR_W, 0x3FFC wraps to 0x0000); req_vld <= 1, req_addr <= pc. No issue: req_vld <= 0.
- Priority per edge: rst_n > jump_i > stall_i > normal.
- Reset: pc=RESET_PC, state=IDLE, req_vld=0, hold_vld=0, Instr_o=0, addr_o=0, valid_o=0.
- IDLE: no issue, outputs bubble; next state RUN unconditionally.
- RUN, !stall_i: Instr_o<=imem_data_i, addr_o<=req_addr, valid_o<=req_vld; if !req_vld outputs load 0/0/0.
- RUN, stall_i: outputs hold; if req_vld, hold <= {imem_data_i, req_addr}, state->SKID; else stay RUN.
- SKID, stall_i: outputs and hold unchanged; no issue.
- SKID, !stall_i: outputs <= hold (valid_o=1), hold_vld<=0, state->RUN; issue at pc occurs this same cycle.
- jump_i (any state but reset): pc <= {jump_addr_i[ADDR_W-1:2],2'b00}; req_vld<=0; hold_vld<=0; outputs <= 0/0/0 even if stall_i; state->RUN.
- Invariant: each issued address reaches Instr_o exactly once, in issue order, unless flushed by jump or reset.

## Timing
- Reset low from edge E0: E1 IDLE->RUN; issue RESET_PC in cycle E1–E2; first valid_o=1 at E3.
- Fetch latency: issue in cycle n -> output registered at edge ending cycle n+1 (two edges from issue cycle start).
- Steady state with stall_i=0: one instruction per cycle, addresses +4 consecutive.
- Jump asserted in cycle j: bubble at edge ending j, target issued cycle j+1, target on outputs at edge ending j+2; exactly 2 bubbles between last pre-jump valid and target (outputs 0/0/0).
- Stall of k cycles: outputs frozen k edges; first unstalled edge delivers held word; next word follows immediately, no gap.
- Reset mid-stall or mid-SKID: hold and req discarded, same reset values.

## Test plan
- Reset: hold rst_n=1 three cycles, release -> valid_o=0 at E1,E2; E3 Instr_o=mem[0x0000], addr_o=0x0000, valid_o=1; E4 addr_o=0x0004.
- Wrap: jump to 0x3FF8, run -> addr_o sequence 0x3FF8, 0x3FFC, 0x0000, 0x0004, all valid.
- Stall: streaming at addr_o=0x0010, stall_i=1 for 3 cycles -> outputs frozen at 0x0010 for 3 edges, imem_en_o=0 during stall; release -> 0x0014, 0x0018 back-to-back, no duplicate/missing.
- Jump: jump_i=1 with jump_addr_i=0x0103 while streaming -> two edges of 0/0/0 bubbles, then addr_o=0x0100 valid, then 0x0104.
- Jump during SKID: stall 2 cycles, assert jump_i=1 (stall_i=1) to 0x0200 -> held word discarded, outputs 0/0/0; drop stall -> 0x0200 appears 2 edges after jump edge.
- Reset mid-stall: SKID with hold full, rst_n=1 one cycle -> all outputs 0, restart from RESET_PC with timing of scenario 1.
